adc_iq_axis_source: RTL and testbench

- Upstream stage of dsp_subsystem. Converts raw ADC I/Q sample strobes into the 32-bit AXI-Stream sample feed consumed on tdata_s/tvalid_s/tready_s.
- Applies optional integer decimation and buffers samples in a small first-word-fall-through (FWFT) FIFO to absorb backpressure.
- Reports lost samples through a sticky overflow flag and a drop counter, both readable by the AHB register file.

---
 rtl/adc_iq_axis_source.sv | 147 ++++++++++++++
 tb/tb_adc_iq_axis_source.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_iq_axis_source.sv
// adc_iq_axis_source
// Turns raw ADC I/Q sample strobes into a 32-bit AXI-Stream sample feed.
// Accepted strobes can be decimated by an integer ratio. Kept samples go into
// a small first-word-fall-through FIFO that absorbs downstream backpressure.
// Lost samples are reported through a sticky overflow flag and a saturating
// drop counter.
//
// Ports:
//   hclk, hreset         clock (rising edge) / asynchronous active-high reset
//   ce, enable           input-side clock enable / capture enable
//   adc_i, adc_q         DW-bit in-phase / quadrature sample
//   adc_valid            one-cycle sample strobe
//   decim                decimation ratio (0 and 1 both keep every sample)
//   tdata_m              {Q, I} FIFO head; I in [DW-1:0], Q in [2DW-1:DW]
//   tvalid_m, tready_m   AXI-Stream handshake
//   fifo_level           FIFO occupancy
//   overflow             sticky flag, set when a kept sample is dropped
//   overflow_clr         single-cycle clear of overflow and drop_cnt
//   drop_cnt             saturating count of dropped samples
module adc_iq_axis_source #(
    parameter int unsigned DW         = 16,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned LW         = 5
) (
    input  logic            hclk,
    input  logic            hreset,
    input  logic            ce,
    input  logic            enable,
    input  logic [DW-1:0]   adc_i,
    input  logic [DW-1:0]   adc_q,
    input  logic            adc_valid,
    input  logic [7:0]      decim,
    output logic [2*DW-1:0] tdata_m,
    output logic            tvalid_m,
    input  logic            tready_m,
    output logic [LW-1:0]   fifo_level,
    output logic            overflow,
    input  logic            overflow_clr,
    output logic [15:0]     drop_cnt
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned TW = 2 * DW;
    localparam int unsigned CW = 16;
    localparam int unsigned DCW = 8;

    logic [TW-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  rd_ptr_nxt;
    logic [DCW-1:0] dcnt;
    logic [DCW-1:0] dcnt_nxt;
    logic [DCW-1:0] dmax;
    logic           accept;
    logic           keep;
    logic           full;
    logic           pop;
    logic           push_ok;
    logic           drop;
    logic [TW-1:0]  din;
    logic [TW-1:0]  head_nxt;
    logic [LW-1:0]  level_after_pop;
    logic [LW-1:0]  level_nxt;
    logic           overflow_nxt;
    logic [CW-1:0]  drop_cnt_nxt;

    // Strobe acceptance and decimation counter; the wrap compare uses >= so a
    // ratio lowered mid-run below the current count still wraps promptly.
    always_comb begin
        dmax     = (decim > DCW'(1)) ? (decim - DCW'(1)) : DCW'(0);
        accept   = ce & enable & adc_valid;
        keep     = accept & (dcnt == DCW'(0));
        dcnt_nxt = dcnt;
        if (!enable) begin
            dcnt_nxt = DCW'(0);
        end else if (accept) begin
            dcnt_nxt = (dcnt >= dmax) ? DCW'(0) : (dcnt + DCW'(1));
        end
    end

    // FIFO bookkeeping and the next head value for the registered FWFT output.
    always_comb begin
        din             = {adc_q, adc_i};
        pop             = tvalid_m & tready_m;
        full            = (fifo_level == LW'(FIFO_DEPTH));
        push_ok         = keep & (~full | pop);
        drop            = keep & full & ~pop;
        level_after_pop = fifo_level - LW'(pop);
        level_nxt       = level_after_pop + LW'(push_ok);
        rd_ptr_nxt      = rd_ptr + AW'(pop);
        head_nxt        = mem[rd_ptr_nxt];
        if (level_nxt == LW'(0)) begin
            head_nxt = '0;
        end else if (push_ok && (level_after_pop == LW'(0))) begin
            // The pushed word becomes the head; it is not in mem yet.
            head_nxt = din;
        end
    end

    // Drop accounting; a drop in the same cycle as a clear wins.
    always_comb begin
        overflow_nxt = overflow;
        drop_cnt_nxt = drop_cnt;
        if (drop) begin
            overflow_nxt = 1'b1;
            if (overflow_clr) begin
                drop_cnt_nxt = CW'(1);
            end else if (drop_cnt != {CW{1'b1}}) begin
                drop_cnt_nxt = drop_cnt + CW'(1);
            end
        end else if (overflow_clr) begin
            overflow_nxt = 1'b0;
            drop_cnt_nxt = '0;
        end
    end

    // Control and output registers.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            dcnt       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            tvalid_m   <= 1'b0;
            tdata_m    <= '0;
            overflow   <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            dcnt       <= dcnt_nxt;
            wr_ptr     <= wr_ptr + AW'(push_ok);
            rd_ptr     <= rd_ptr_nxt;
            fifo_level <= level_nxt;
            tvalid_m   <= (level_nxt != LW'(0));
            tdata_m    <= head_nxt;
            overflow   <= overflow_nxt;
            drop_cnt   <= drop_cnt_nxt;
        end
    end

    // Sample storage; contents are don't-care until written.
    always_ff @(posedge hclk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: tb/tb_adc_iq_axis_source.sv
// Bench for adc_iq_axis_source: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expected beats.
module tb_adc_iq_axis_source;

    localparam int unsigned DW         = 16;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned LW         = 5;

    logic            hclk = 1'b0;
    logic            hreset = 1'b0;
    logic            ce = 1'b1;
    logic            enable = 1'b0;
    logic [DW-1:0]   adc_i = '0;
    logic [DW-1:0]   adc_q = '0;
    logic            adc_valid = 1'b0;
    logic [7:0]      decim = 8'd1;
    logic [2*DW-1:0] tdata_m;
    logic            tvalid_m;
    logic            tready_m = 1'b0;
    logic [LW-1:0]   fifo_level;
    logic            overflow;
    logic            overflow_clr = 1'b0;
    logic [15:0]     drop_cnt;

    adc_iq_axis_source #(.DW(DW), .FIFO_DEPTH(FIFO_DEPTH), .LW(LW)) dut (
        .hclk(hclk), .hreset(hreset), .ce(ce), .enable(enable),
        .adc_i(adc_i), .adc_q(adc_q), .adc_valid(adc_valid), .decim(decim),
        .tdata_m(tdata_m), .tvalid_m(tvalid_m), .tready_m(tready_m),
        .fifo_level(fifo_level), .overflow(overflow),
        .overflow_clr(overflow_clr), .drop_cnt(drop_cnt)
    );

    always #5 hclk = ~hclk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: kept samples are every r-th accepted strobe since
    // enable rose; the FIFO is a queue of at most FIFO_DEPTH words.
    logic [31:0] mq[$];
    int          m_acc  = 0;
    logic        m_ovf  = 1'b0;
    int          m_drop = 0;
    logic        m_pop;
    logic        m_keep;
    logic        m_dropev;
    int          m_r;

    always @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            mq.delete();
            m_acc  = 0;
            m_ovf  = 1'b0;
            m_drop = 0;
        end else begin
            m_pop  = (mq.size() != 0) && tready_m;
            m_r    = (decim < 8'd2) ? 1 : int'(decim);
            m_keep = 1'b0;
            if (!enable) begin
                m_acc = 0;
            end else if (ce && adc_valid) begin
                m_keep = ((m_acc % m_r) == 0);
                m_acc++;
            end
            m_dropev = m_keep && !m_pop && (mq.size() == FIFO_DEPTH);
            if (m_pop) void'(mq.pop_front());
            if (m_keep && !m_dropev) mq.push_back({adc_q, adc_i});
            if (m_dropev) begin
                m_ovf  = 1'b1;
                m_drop = overflow_clr ? 1 : ((m_drop < 65535) ? m_drop + 1 : 65535);
            end else if (overflow_clr) begin
                m_ovf  = 1'b0;
                m_drop = 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge hclk) begin
        check("tvalid", 32'(tvalid_m), 32'(mq.size() != 0));
        if (mq.size() != 0) check("tdata", tdata_m, mq[0]);
        check("level", 32'(fifo_level), 32'(mq.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    end

    // Record completed handshakes.
    logic [31:0] beats[$];
    always @(posedge hclk) begin
        if (!hreset && tvalid_m && tready_m) beats.push_back(tdata_m);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge hclk);
    endtask

    task automatic strobe(input logic [15:0] i, input logic [15:0] q);
        adc_i = i;
        adc_q = q;
        adc_valid = 1'b1;
        @(negedge hclk);
        adc_valid = 1'b0;
    endtask

    task automatic restart_capture();
        enable = 1'b0;
        idle(1);
        enable = 1'b1;
    endtask

    initial begin
        #1 hreset = 1'b1;
        idle(3);
        check("rst_tvalid", 32'(tvalid_m), 32'd0);
        check("rst_tdata", tdata_m, 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        hreset = 1'b0;
        idle(2);

        // Keep every sample, no backpressure.
        beats.delete();
        decim = 8'd1; tready_m = 1'b1; enable = 1'b1;
        adc_i = 16'd0; adc_q = 16'h8000; adc_valid = 1'b1;
        @(negedge hclk);
        check("first_tvalid", 32'(tvalid_m), 32'd1);
        check("first_tdata", tdata_m, 32'h8000_0000);
        for (int n = 1; n < 20; n++) begin
            adc_i = 16'(n); adc_q = 16'(32'h8000 + n);
            @(negedge hclk);
            check("lvl_le1", 32'(fifo_level <= LW'(1)), 32'd1);
        end
        adc_valid = 1'b0;
        idle(3);
        check("t1_beats", 32'(beats.size()), 32'd20);
        for (int k = 0; k < 20 && k < beats.size(); k++)
            check("t1_beat", beats[k], {16'(32'h8000 + k), 16'(k)});

        // Decimate by 4.
        enable = 1'b0; decim = 8'd4; idle(1); enable = 1'b1;
        beats.delete();
        for (int n = 0; n < 40; n++) strobe(16'(n), 16'd0);
        idle(3);
        check("t2_beats", 32'(beats.size()), 32'd10);
        for (int k = 0; k < 10 && k < beats.size(); k++)
            check("t2_beat", beats[k], 32'(4 * k));

        // Fill with backpressure, overflow by 4, then drain.
        enable = 1'b0; decim = 8'd1; tready_m = 1'b0; idle(1); enable = 1'b1;
        for (int n = 0; n < 20; n++) strobe(16'(n), 16'd0);
        check("t3_level", 32'(fifo_level), 32'd16);
        check("t3_overflow", 32'(overflow), 32'd1);
        check("t3_drop", 32'(drop_cnt), 32'd4);
        beats.delete();
        tready_m = 1'b1;
        idle(20);
        check("t3_beats", 32'(beats.size()), 32'd16);
        for (int k = 0; k < 16 && k < beats.size(); k++)
            check("t3_beat", beats[k], 32'(k));

        // Full FIFO with simultaneous pop and push.
        tready_m = 1'b0;
        restart_capture();
        for (int n = 0; n < 16; n++) strobe(16'(n + 32), 16'd0);
        check("t4_full", 32'(fifo_level), 32'd16);
        tready_m = 1'b1;
        strobe(16'd100, 16'd0);
        tready_m = 1'b0;
        check("t4_level", 32'(fifo_level), 32'd16);
        check("t4_drop", 32'(drop_cnt), 32'd4);
        check("t4_head", tdata_m, 32'd33);

        // Clear in the same cycle as a drop, then saturation.
        overflow_clr = 1'b1;
        strobe(16'd200, 16'd0);
        overflow_clr = 1'b0;
        check("t5_ovf", 32'(overflow), 32'd1);
        check("t5_drop", 32'(drop_cnt), 32'd1);
        overflow_clr = 1'b1; idle(1); overflow_clr = 1'b0;
        check("t5_clr_ovf", 32'(overflow), 32'd0);
        check("t5_clr_drop", 32'(drop_cnt), 32'd0);
        adc_valid = 1'b1;
        repeat (70000) @(negedge hclk);
        adc_valid = 1'b0;
        check("t5_sat", 32'(drop_cnt), 32'h0000_FFFF);
        overflow_clr = 1'b1; idle(1); overflow_clr = 1'b0;
        check("t5_sat_clr", 32'(drop_cnt), 32'd0);

        // Asynchronous reset with 8 entries queued.
        tready_m = 1'b1;
        idle(20);
        tready_m = 1'b0;
        restart_capture();
        for (int n = 0; n < 8; n++) strobe(16'(n + 64), 16'd7);
        check("t6_pre_tvalid", 32'(tvalid_m), 32'd1);
        check("t6_pre_level", 32'(fifo_level), 32'd8);
        #2 hreset = 1'b1;
        #1;
        check("t6_async_tvalid", 32'(tvalid_m), 32'd0);
        check("t6_async_level", 32'(fifo_level), 32'd0);
        @(negedge hclk);
        hreset = 1'b0;
        tready_m = 1'b1;
        beats.delete();
        ce = 1'b0;
        strobe(16'h0011, 16'h0022);
        ce = 1'b1;
        strobe(16'h0055, 16'h0066);
        idle(3);
        check("t6_beats", 32'(beats.size()), 32'd1);
        if (beats.size() > 0) check("t6_first", beats[0], 32'h0066_0055);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
